// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared FSM state type, funct3 encodings and alignment check for the load/store unit
package riscv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RDWAIT,
      DONE,
      DRAIN
   } lsu_state_e;

   localparam logic [2:0] LSU_LB  = 3'b000;
   localparam logic [2:0] LSU_LH  = 3'b001;
   localparam logic [2:0] LSU_LW  = 3'b010;
   localparam logic [2:0] LSU_LD  = 3'b011;
   localparam logic [2:0] LSU_LBU = 3'b100;
   localparam logic [2:0] LSU_LHU = 3'b101;
   localparam logic [2:0] LSU_LWU = 3'b110;

   // funct3[1:0] encodes the access size for both signed and unsigned forms
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [2:0] off);
      case (funct3[1:0])
         2'b01:   return off[0];
         2'b10:   return |off[1:0];
         2'b11:   return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - store lane replication/strobes and load byte extract with sign/zero extension
module riscv_lsu_align
   import riscv_pkg::*;
#(
   parameter int DW     = 64,
   parameter int STRB_W = DW/8
) (
   input  logic [2:0]        funct3_i,
   input  logic [2:0]        off_i,
   input  logic [DW-1:0]     st_data_i,
   input  logic [DW-1:0]     ld_dword_i,
   output logic [STRB_W-1:0] st_strb_o,
   output logic [DW-1:0]     st_wdata_o,
   output logic [DW-1:0]     ld_data_o
);

   logic [DW-1:0] ld_shifted;

   always_comb begin
      ld_shifted = ld_dword_i >> {off_i, 3'b000};

      case (funct3_i[1:0])
         2'b00: begin
            st_strb_o  = STRB_W'(8'h01) << off_i;
            st_wdata_o = {(DW/8){st_data_i[7:0]}};
         end
         2'b01: begin
            st_strb_o  = STRB_W'(8'h03) << off_i;
            st_wdata_o = {(DW/16){st_data_i[15:0]}};
         end
         2'b10: begin
            st_strb_o  = STRB_W'(8'h0F) << off_i;
            st_wdata_o = {(DW/32){st_data_i[31:0]}};
         end
         default: begin
            st_strb_o  = {STRB_W{1'b1}};
            st_wdata_o = st_data_i;
         end
      endcase

      case (funct3_i)
         LSU_LB:  ld_data_o = {{(DW-8){ld_shifted[7]}},   ld_shifted[7:0]};
         LSU_LH:  ld_data_o = {{(DW-16){ld_shifted[15]}}, ld_shifted[15:0]};
         LSU_LW:  ld_data_o = {{(DW-32){ld_shifted[31]}}, ld_shifted[31:0]};
         LSU_LBU: ld_data_o = {{(DW-8){1'b0}},  ld_shifted[7:0]};
         LSU_LHU: ld_data_o = {{(DW-16){1'b0}}, ld_shifted[15:0]};
         LSU_LWU: ld_data_o = {{(DW-32){1'b0}}, ld_shifted[31:0]};
         LSU_LD:  ld_data_o = ld_dword_i;
         default: ld_data_o = ld_dword_i;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - memory-stage load/store unit with req/gnt/rvalid bus FSM; RISCV_LSU_LRSC_EN adds the LR/SC reservation
module riscv_lsu
   import riscv_pkg::*;
#(
   parameter int DW     = 64,
   parameter int STRB_W = DW/8
) (
   input  logic              i_riscv_lsu_clk,
   input  logic              i_riscv_lsu_rst_n,
   input  logic              i_riscv_lsu_flush,
   input  logic              i_riscv_lsu_memread_m,
   input  logic              i_riscv_lsu_memwrite_m,
   input  logic              i_riscv_lsu_lr_m,
   input  logic              i_riscv_lsu_sc_m,
   input  logic [2:0]        i_riscv_lsu_funct3_m,
   input  logic [DW-1:0]     i_riscv_lsu_addr_m,
   input  logic [DW-1:0]     i_riscv_lsu_wdata_m,
   output logic              o_riscv_lsu_dmem_req,
   output logic              o_riscv_lsu_dmem_we,
   output logic [DW-1:0]     o_riscv_lsu_dmem_addr,
   output logic [DW-1:0]     o_riscv_lsu_dmem_wdata,
   output logic [STRB_W-1:0] o_riscv_lsu_dmem_strb,
   input  logic              i_riscv_lsu_dmem_gnt,
   input  logic              i_riscv_lsu_dmem_rvalid,
   input  logic [DW-1:0]     i_riscv_lsu_dmem_rdata,
   output logic              o_riscv_lsu_stall,
   output logic [DW-1:0]     o_riscv_lsu_memload_m,
   output logic [DW-1:0]     o_riscv_lsu_rddata_sc_m,
   output logic              o_riscv_lsu_ld_misalign,
   output logic              o_riscv_lsu_st_misalign
);

   lsu_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [DW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic [DW-1:0]     ld_buf_q, ld_buf_d;

   logic              misalign;
   logic              access;
   logic              sc_fail;
   logic              bus_access;
   logic [STRB_W-1:0] st_strb;
   logic [DW-1:0]     st_wdata;
   logic [DW-1:0]     ld_ext;

   assign misalign   = lsu_misaligned(i_riscv_lsu_funct3_m, i_riscv_lsu_addr_m[2:0]);
   assign access     = (i_riscv_lsu_memread_m | i_riscv_lsu_memwrite_m) & ~misalign;
   assign bus_access = access & ~sc_fail;

   assign o_riscv_lsu_ld_misalign = i_riscv_lsu_memread_m & misalign;
   assign o_riscv_lsu_st_misalign = i_riscv_lsu_memwrite_m & misalign;
   assign o_riscv_lsu_stall       = bus_access & (state_q != DONE);
   assign o_riscv_lsu_memload_m   = i_riscv_lsu_memread_m ? ld_ext : '0;

   assign o_riscv_lsu_dmem_req   = req_q;
   assign o_riscv_lsu_dmem_we    = we_q;
   assign o_riscv_lsu_dmem_addr  = addr_q;
   assign o_riscv_lsu_dmem_wdata = wdata_q;
   assign o_riscv_lsu_dmem_strb  = strb_q;

   riscv_lsu_align #(
      .DW     (DW),
      .STRB_W (STRB_W)
   ) u_align (
      .funct3_i   (i_riscv_lsu_funct3_m),
      .off_i      (i_riscv_lsu_addr_m[2:0]),
      .st_data_i  (i_riscv_lsu_wdata_m),
      .ld_dword_i (ld_buf_q),
      .st_strb_o  (st_strb),
      .st_wdata_o (st_wdata),
      .ld_data_o  (ld_ext)
   );

`ifdef RISCV_LSU_LRSC_EN
   logic            res_valid_q, res_valid_d;
   logic [DW-4:0]   res_addr_q, res_addr_d;
   logic            res_hit;

   assign res_hit = res_valid_q & (res_addr_q == i_riscv_lsu_addr_m[DW-1:3]);
   assign sc_fail = i_riscv_lsu_sc_m & i_riscv_lsu_memwrite_m & access & ~res_hit;
   assign o_riscv_lsu_rddata_sc_m = {{(DW-1){1'b0}}, sc_fail};

   // Reservation changes only when the owning access completes so a successful
   // SC still sees its match while sitting in DONE.
   always_comb begin
      res_valid_d = res_valid_q;
      res_addr_d  = res_addr_q;
      if (i_riscv_lsu_flush) begin
         res_valid_d = 1'b0;
      end else begin
         if (state_q == DONE && i_riscv_lsu_memread_m && i_riscv_lsu_lr_m) begin
            res_valid_d = 1'b1;
            res_addr_d  = i_riscv_lsu_addr_m[DW-1:3];
         end
         if (state_q == DONE && i_riscv_lsu_memwrite_m && res_hit) begin
            res_valid_d = 1'b0;
         end
         if (i_riscv_lsu_sc_m && i_riscv_lsu_memwrite_m && access &&
             (state_q == DONE || sc_fail)) begin
            res_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
      if (!i_riscv_lsu_rst_n) begin
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_addr_q  <= res_addr_d;
      end
   end
`else
   logic lrsc_unused;

   assign lrsc_unused             = i_riscv_lsu_lr_m & i_riscv_lsu_sc_m;
   assign sc_fail                 = 1'b0;
   assign o_riscv_lsu_rddata_sc_m = '0;
`endif

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      ld_buf_d = ld_buf_q;

      case (state_q)
         IDLE: begin
            if (bus_access && !i_riscv_lsu_flush) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = i_riscv_lsu_memwrite_m;
               addr_d  = {i_riscv_lsu_addr_m[DW-1:3], 3'b000};
               wdata_d = st_wdata;
               strb_d  = st_strb;
            end
         end
         REQ: begin
            // A grant in the flush cycle still commits; reads then owe a response.
            if (i_riscv_lsu_dmem_gnt) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               if (we_q) state_d = i_riscv_lsu_flush ? IDLE : DONE;
               else      state_d = i_riscv_lsu_flush ? DRAIN : RDWAIT;
            end else if (i_riscv_lsu_flush) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
            end
         end
         RDWAIT: begin
            if (i_riscv_lsu_dmem_rvalid) begin
               ld_buf_d = i_riscv_lsu_dmem_rdata;
               state_d  = i_riscv_lsu_flush ? IDLE : DONE;
            end else if (i_riscv_lsu_flush) begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         DRAIN: begin
            if (i_riscv_lsu_dmem_rvalid) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
      if (!i_riscv_lsu_rst_n) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         ld_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         ld_buf_q <= ld_buf_d;
      end
   end

endmodule
